// File: rtl/mul_result_unit_if.sv
// Issue, product and result signals between the EX-stage multiplier, the
// mul_result_unit, the MA stage and the hazard unit.
// master: the surrounding pipeline. slave: mul_result_unit.
interface mul_result_unit_if #(
    parameter int REG_ADDR_W = 5
);
    // Issue side
    logic                  i_issue_valid;
    logic [1:0]            i_issue_op;
    logic [REG_ADDR_W-1:0] i_issue_rd;
    logic                  o_issue_ready;
    logic                  i_flush;

    // Multiplier output
    logic [63:0]           i_product;
    logic                  i_product_valid;
    logic                  i_completing_next_cycle;

    // Result towards MA
    logic                  o_result_valid;
    logic [31:0]           o_result;
    logic [REG_ADDR_W-1:0] o_result_rd;
    logic                  i_result_ready;

    // Hazard unit and error reporting
    logic                  o_stall;
    logic                  o_err_timeout;
    logic                  o_err_unexpected;

    modport master (
        output i_issue_valid, i_issue_op, i_issue_rd, i_flush,
        output i_product, i_product_valid, i_completing_next_cycle,
        output i_result_ready,
        input  o_issue_ready, o_result_valid, o_result, o_result_rd,
        input  o_stall, o_err_timeout, o_err_unexpected
    );

    modport slave (
        input  i_issue_valid, i_issue_op, i_issue_rd, i_flush,
        input  i_product, i_product_valid, i_completing_next_cycle,
        input  i_result_ready,
        output o_issue_ready, o_result_valid, o_result, o_result_rd,
        output o_stall, o_err_timeout, o_err_unexpected
    );
endinterface

// File: rtl/mul_result_unit.sv
// Purpose: tracks the single in-flight multiply, captures its product, selects
//          the 32-bit result and holds it for MA; drives stall and sticky errors.
// Latency: issue at N, product at N+PIPE_STAGES, o_result_valid at N+PIPE_STAGES+1.
// Backpressure: result held (o_result_valid high, o_issue_ready low) until i_result_ready.
// Ports: i_clk, i_rst (synchronous, active-high); bus = mul_result_unit_if.slave.
module mul_result_unit #(
    parameter int PIPE_STAGES = 4,
    parameter int REG_ADDR_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mul_result_unit_if.slave  bus
);
    localparam int              CNT_W   = $clog2(PIPE_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_STAGES);
    localparam logic [1:0]      OP_MUL  = 2'b00;

    typedef enum logic [2:0] {
        ST_QUIET,
        ST_IDLE,
        ST_BUSY,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [1:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [31:0]           result_q;
    logic [REG_ADDR_W-1:0] result_rd_q;
    logic                  result_valid_q;
    logic                  err_timeout_q;
    logic                  err_unexpected_q;

    logic cnt_at_max;
    logic issue_take;
    logic capture;
    logic set_timeout;
    logic set_unexpected;
    logic issue_ready;
    logic stall;
    logic cnt_entry;
    logic cnt_run;

    assign cnt_at_max = (cnt_q == CNT_MAX);

    // Next-state and combinational outputs
    always_comb begin
        state_d        = state_q;
        issue_take     = 1'b0;
        capture        = 1'b0;
        set_timeout    = 1'b0;
        set_unexpected = 1'b0;
        issue_ready    = 1'b0;
        stall          = 1'b0;

        case (state_q)
            // Post-reset window: anything the multiplier still emits is
            // left over from before reset and is dropped silently.
            ST_QUIET: begin
                if (cnt_at_max) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                issue_ready = 1'b1;
                if (bus.i_product_valid) begin
                    set_unexpected = 1'b1;
                end
                // A flush kills a same-cycle issue.
                if (bus.i_issue_valid && !bus.i_flush) begin
                    issue_take = 1'b1;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // No stall once the multiplier signals completion, nor in
                // the cycle the product itself arrives.
                stall = !bus.i_completing_next_cycle && !bus.i_product_valid;
                if (bus.i_product_valid) begin
                    if (bus.i_flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (bus.i_flush) begin
                    state_d = ST_DRAIN;
                end else if (cnt_at_max) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (bus.i_product_valid) begin
                    set_unexpected = 1'b1;
                end
                if (bus.i_result_ready || bus.i_flush) begin
                    state_d = ST_IDLE;
                end
            end

            // Flushed op still inside the multiplier: wait for its product
            // and throw it away, so it is not mistaken for a later issue.
            ST_DRAIN: begin
                if (bus.i_product_valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_at_max) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_QUIET;
            end
        endcase
    end

    // Cycle counter: restarts on entry to a counting state, saturates.
    always_comb begin
        cnt_entry = (state_d != state_q) &&
                    ((state_d == ST_QUIET) || (state_d == ST_BUSY) || (state_d == ST_DRAIN));
        cnt_run   = (state_q == ST_QUIET) || (state_q == ST_BUSY) || (state_q == ST_DRAIN);
        cnt_d     = cnt_q;
        if (cnt_entry) begin
            cnt_d = '0;
        end else if (cnt_run && !cnt_at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= ST_QUIET;
            cnt_q            <= '0;
            op_q             <= '0;
            rd_q             <= '0;
            result_q         <= '0;
            result_rd_q      <= '0;
            result_valid_q   <= 1'b0;
            err_timeout_q    <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_valid_q <= (state_d == ST_HOLD);

            if (issue_take) begin
                op_q <= bus.i_issue_op;
                rd_q <= bus.i_issue_rd;
            end

            // MUL returns the low word; all high-half variants return bits 63:32.
            if (capture) begin
                result_q    <= (op_q == OP_MUL) ? bus.i_product[31:0] : bus.i_product[63:32];
                result_rd_q <= rd_q;
            end

            if (set_timeout) begin
                err_timeout_q <= 1'b1;
            end
            if (set_unexpected) begin
                err_unexpected_q <= 1'b1;
            end
        end
    end

    assign bus.o_issue_ready    = issue_ready;
    assign bus.o_stall          = stall;
    assign bus.o_result_valid   = result_valid_q;
    assign bus.o_result         = result_q;
    assign bus.o_result_rd      = result_rd_q;
    assign bus.o_err_timeout    = err_timeout_q;
    assign bus.o_err_unexpected = err_unexpected_q;
endmodule

// File: doc/mul_result_unit.md
# mul_result_unit

Downstream companion to the pipelined 33x33 multiplier in the EX-stage ALU. Tracks the single in-flight multiply from issue to retirement: it latches the opcode and destination register at issue and captures the 64-bit product when it emerges. It then selects the architectural 32-bit result (low or high half) and holds it until the MA stage accepts it. It also drives the hazard-unit stall and sticky protocol-error flags.

## Interface
Parameters:
- PIPE_STAGES, 4: multiplier latency in cycles; must equal the multiplier's pipeline depth.
- REG_ADDR_W, 5: destination register index width.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_issue_valid  in  1  a multiply is presented to the multiplier this cycle.
- i_issue_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_issue_rd  in  REG_ADDR_W  destination register.
- o_issue_ready  out  1  unit can accept an issue this cycle.
- i_flush  in  1  kill any in-flight or held multiply.
- i_product  in  64  multiplier product output.
- i_product_valid  in  1  multiplier output valid.
- i_completing_next_cycle  in  1  multiplier completes next cycle.
- o_result_valid  out  1  held result available to MA.
- o_result  out  32  selected result.
- o_result_rd  out  REG_ADDR_W  destination of held result.
- i_result_ready  in  1  MA accepts result.
- o_stall  out  1  hazard-unit stall request.
- o_err_timeout  out  1  sticky: product missing at expected cycle.
- o_err_unexpected  out  1  sticky: product_valid with no op outstanding.

## Operation
- Reset values:
  - state QUIET, counter 0.
  - o_result_valid 0, o_result 0, o_result_rd 0.
  - o_issue_ready 0, o_stall 0, both error flags 0.
- Counter: cleared on any entry to QUIET, BUSY or DRAIN; increments every cycle in those states; saturates at PIPE_STAGES.
- QUIET: discards any product_valid without flagging it. Moves to IDLE when the counter reaches PIPE_STAGES.
- IDLE: o_issue_ready=1.
  - i_issue_valid & ~i_flush: latch op and rd, go to BUSY.
  - Flush wins over a same-cycle issue; the issue is dropped.
  - product_valid in IDLE sets o_err_unexpected.
- BUSY: o_stall = ~i_completing_next_cycle.
  - product_valid & ~i_flush: capture the result, go to HOLD.
    - MUL: o_result = i_product[31:0].
    - MULH, MULHSU, MULHU: o_result = i_product[63:32].
    - o_result_rd = latched rd.
  - product_valid & i_flush: discard the product, go to IDLE.
  - i_flush alone: go to DRAIN.
  - Counter == PIPE_STAGES with no product_valid: set o_err_timeout, go to IDLE.
- HOLD: o_result_valid=1.
  - i_result_ready or i_flush: go to IDLE; o_result_valid clears next cycle.
  - o_result and o_result_rd hold their last values until the next capture.
  - product_valid in HOLD sets o_err_unexpected.
- DRAIN: o_issue_ready=0, o_stall=0.
  - product_valid: discard, go to IDLE.
  - Counter == PIPE_STAGES with no product_valid: set o_err_timeout, go to IDLE.
- Error flags clear only on reset.
- Reset mid-operation: unconditional return to QUIET. Any surviving multiplier output is absorbed silently.

## Timing
- Issue accepted at cycle N, so the unit is in BUSY from N+1.
- Multiplier output valid at N+PIPE_STAGES (N+4). The counter reads PIPE_STAGES-1 in that cycle.
- o_result_valid is registered and rises at N+5.
- o_stall:
  - 0 in cycle N.
  - 1 for N+1..N+2.
  - 0 at N+3, when i_completing_next_cycle=1.
  - 0 at N+4.
- With i_result_ready held high, HOLD lasts 1 cycle (N+5) and IDLE resumes at N+6.
- Maximum issue rate is one multiply per PIPE_STAGES+2 cycles.
- Timeout is detected at N+5: the error flag is set and the unit is in IDLE at N+6.
- QUIET lasts PIPE_STAGES+1 cycles after reset deasserts.

## Test plan
- MUL: issue op=00 with the product driven as 0xFFFFFFFE_00000001 at N+4 -> o_result=0x00000001 and o_result_valid=1 at N+5; o_stall=1 exactly at N+1 and N+2.
- MULHU: same product -> o_result=0xFFFFFFFE, o_result_rd as issued (e.g. 5'd7). MULH with product 0xFFFFFFFF_FFFFFFFF -> 0xFFFFFFFF.
- Backpressure: i_result_ready=0 for 10 cycles -> o_result_valid stays 1, result stable, o_issue_ready=0; release -> IDLE next cycle.
- Flush: at N+2 -> DRAIN; product_valid at N+4 is discarded; o_result_valid never asserts; no error flag set; o_issue_ready=1 at N+5.
- Errors:
  - Omit product_valid after an issue -> o_err_timeout=1 from N+6 and stays sticky.
  - Pulse product_valid in IDLE -> o_err_unexpected=1.
- Reset mid-op: assert i_rst at N+2, then pulse product_valid 2 cycles after deassert -> no error; o_issue_ready rises PIPE_STAGES+1 cycles after deassert.
